// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between the in-order
//   pipeline writeback stage (always wins) and a long-latency (LL) unit
//   that returns results on a valid/ready channel. It also tracks LL
//   destinations in a pending scoreboard for decode hazard checks, limits
//   the number of in-flight LL ops, and asks the pipeline for a writeback
//   bubble when an LL result has been refused for too long.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_en/wb_rd/wb_data        pipeline writeback (no backpressure)
//   ll_valid/ll_rd/ll_data     LL result channel, ll_ready = accepted
//   iss_valid/iss_rd           LL issue from decode, iss_ready = permitted
//   chk_rs1/chk_rs2/chk_rd     decode registers checked against pending
//   hazard                     any checked register is pending
//   pipe_stall_req             pipeline must inject a writeback bubble
//   rf_write_en/rf_rd/rf_write_data  register file write port (sampled on negedge)
//   pending                    scoreboard bitmap, bit 0 always 0
//   outstanding                issued, not yet retired LL ops
module regfile_wb_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 4,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  input  logic             ll_valid,
  input  logic [4:0]       ll_rd,
  input  logic [31:0]      ll_data,
  output logic             ll_ready,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  output logic             iss_ready,
  input  logic [4:0]       chk_rs1,
  input  logic [4:0]       chk_rs2,
  input  logic [4:0]       chk_rd,
  output logic             hazard,
  output logic             pipe_stall_req,
  output logic             rf_write_en,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_write_data,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] outstanding
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

  logic             a_act;
  logic             do_issue;
  logic             do_retire;
  logic             do_dec;
  logic [31:0]      pending_next;
  logic [CNT_W-1:0] outstanding_next;
  logic [SW-1:0]    starve_cnt;
  logic [SW-1:0]    starve_next;

  // Write-port grant: purely combinational so it settles well before the
  // register file's falling-edge sample.
  always_comb begin
    a_act         = wb_en & (wb_rd != '0);
    ll_ready      = 1'b0;
    rf_write_en   = 1'b0;
    rf_rd         = '0;
    rf_write_data = '0;
    if (a_act) begin
      rf_write_en   = 1'b1;
      rf_rd         = wb_rd;
      rf_write_data = wb_data;
    end else if (ll_valid) begin
      ll_ready      = 1'b1;
      rf_write_en   = (ll_rd != '0);
      rf_rd         = ll_rd;
      rf_write_data = ll_data;
    end
  end

  // Issue readiness uses registered state only, so a same-cycle retire
  // never unblocks a full tracker.
  assign iss_ready = (outstanding < MAX_CNT) & ~pending[iss_rd];
  assign do_issue  = iss_valid & iss_ready;
  assign do_retire = ll_valid & ll_ready;
  // A retire with nothing outstanding is a protocol error: the data is
  // still written but the counter must not underflow.
  assign do_dec    = do_retire & (outstanding != '0);

  assign hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd];

  always_comb begin
    pending_next = pending;
    // Clear before set so a same-register issue/retire leaves the bit set.
    if (do_retire) pending_next[ll_rd] = 1'b0;
    if (do_issue)  pending_next[iss_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    outstanding_next = outstanding;
    if (do_issue && !do_dec)
      outstanding_next = outstanding + CNT_W'(1);
    else if (!do_issue && do_dec)
      outstanding_next = outstanding - CNT_W'(1);
  end

  always_comb begin
    starve_next = '0;
    if (ll_valid && !ll_ready)
      starve_next = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending        <= '0;
      outstanding    <= '0;
      starve_cnt     <= '0;
      pipe_stall_req <= 1'b0;
    end else begin
      pending        <= pending_next;
      outstanding    <= outstanding_next;
      starve_cnt     <= starve_next;
      // The counter returns to zero on acceptance, so the request drops
      // the cycle after the LL result is taken.
      pipe_stall_req <= (starve_next == STARVE_MAX);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        hazard;
  logic        pipe_stall_req;
  logic        rf_write_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data;
  logic [31:0] pending;
  logic [2:0]  outstanding;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
    .pipe_stall_req(pipe_stall_req),
    .rf_write_en(rf_write_en), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .pending(pending), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wb_en = 0; wb_rd = 0; wb_data = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("reset_pending", pending, 32'h0);
    check("reset_outstanding", 32'(outstanding), 32'd0);
    check("reset_stall", 32'(pipe_stall_req), 32'd0);
    check("idle_we", 32'(rf_write_en), 32'd0);

    // Async reset mid-cycle: pending[5]=1, outstanding=2 (second op has rd=0)
    iss_valid = 1; iss_rd = 5; tick();
    iss_rd = 0; tick();
    iss_valid = 0;
    check("pre_rst_pending", pending, 32'h0000_0020);
    check("pre_rst_outstanding", 32'(outstanding), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pending", pending, 32'h0);
    check("async_rst_outstanding", 32'(outstanding), 32'd0);
    check("async_rst_stall", 32'(pipe_stall_req), 32'd0);
    tick();
    rst_n = 1'b1;

    // Issue rd=7 then retire it from the LL unit
    iss_valid = 1; iss_rd = 7; #1;
    check("iss7_ready", 32'(iss_ready), 32'd1);
    tick();
    iss_valid = 0;
    check("iss7_pending", pending, 32'h0000_0080);
    check("iss7_outstanding", 32'(outstanding), 32'd1);
    ll_valid = 1; ll_rd = 7; ll_data = 32'hDEAD_BEEF; #1;
    check("ll7_ready", 32'(ll_ready), 32'd1);
    check("ll7_we", 32'(rf_write_en), 32'd1);
    check("ll7_rd", 32'(rf_rd), 32'd7);
    check("ll7_data", rf_write_data, 32'hDEAD_BEEF);
    tick();
    ll_valid = 0;
    check("ll7_pending_cleared", pending, 32'h0);
    check("ll7_outstanding", 32'(outstanding), 32'd0);

    // Starvation: pipeline holds the port for 4 cycles
    iss_valid = 1; iss_rd = 9; tick();
    iss_valid = 0;
    wb_en = 1; wb_rd = 3; wb_data = 32'h11;
    ll_valid = 1; ll_rd = 9; ll_data = 32'h22; #1;
    check("prio_rd", 32'(rf_rd), 32'd3);
    check("prio_data", rf_write_data, 32'h11);
    check("prio_ll_ready", 32'(ll_ready), 32'd0);
    check("prio_we", 32'(rf_write_en), 32'd1);
    tick(); tick(); tick();
    check("starve3_stall", 32'(pipe_stall_req), 32'd0);
    tick();
    check("starve4_stall", 32'(pipe_stall_req), 32'd1);
    tick();
    check("starve_sat_stall", 32'(pipe_stall_req), 32'd1);
    wb_en = 0; #1;
    check("starve_ll_rd", 32'(rf_rd), 32'd9);
    check("starve_ll_data", rf_write_data, 32'h22);
    check("starve_ll_ready", 32'(ll_ready), 32'd1);
    check("starve_hold_stall", 32'(pipe_stall_req), 32'd1);
    tick();
    ll_valid = 0;
    check("starve_clear_stall", 32'(pipe_stall_req), 32'd0);
    check("starve_outstanding", 32'(outstanding), 32'd0);
    check("starve_pending", pending, 32'h0);

    // Fill to MAX_OUTSTANDING, then retire+issue in the same cycle
    iss_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      iss_rd = 5'(i); tick();
    end
    check("full_outstanding", 32'(outstanding), 32'd4);
    check("full_pending", pending, 32'h0000_001E);
    iss_rd = 6; ll_valid = 1; ll_rd = 2; ll_data = 32'h2; #1;
    check("full_iss_ready", 32'(iss_ready), 32'd0);
    check("full_ll_ready", 32'(ll_ready), 32'd1);
    tick();
    iss_valid = 0; ll_valid = 0; #1;
    check("full_retire_outstanding", 32'(outstanding), 32'd3);
    check("full_retire_pending", pending, 32'h0000_001A);
    check("after_retire_iss_ready", 32'(iss_ready), 32'd1);
    ll_valid = 1;
    ll_rd = 1; tick();
    ll_rd = 3; tick();
    ll_rd = 4; tick();
    ll_valid = 0;
    check("drain_outstanding", 32'(outstanding), 32'd0);
    check("drain_pending", pending, 32'h0);

    // Hazard detection and WAW refusal on pending[10]
    iss_valid = 1; iss_rd = 10; tick();
    iss_valid = 0;
    chk_rs2 = 10; #1;
    check("haz_rs2", 32'(hazard), 32'd1);
    check("waw_iss_ready", 32'(iss_ready), 32'd0);
    iss_valid = 1; tick();
    iss_valid = 0;
    check("waw_ignored_outstanding", 32'(outstanding), 32'd1);
    check("waw_ignored_pending", pending, 32'h0000_0400);
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 11; #1;
    check("haz_none", 32'(hazard), 32'd0);
    chk_rd = 10; #1;
    check("haz_rd", 32'(hazard), 32'd1);
    chk_rd = 0;
    ll_valid = 1; ll_rd = 10; ll_data = 32'hA; tick();
    ll_valid = 0;
    check("haz_retired", pending, 32'h0);

    // wb_rd=0 is not a write: LL gets the port (and nothing is outstanding)
    wb_en = 1; wb_rd = 0; wb_data = 32'h55;
    ll_valid = 1; ll_rd = 4; ll_data = 32'h44; #1;
    check("wb0_ll_ready", 32'(ll_ready), 32'd1);
    check("wb0_rd", 32'(rf_rd), 32'd4);
    check("wb0_data", rf_write_data, 32'h44);
    check("wb0_we", 32'(rf_write_en), 32'd1);
    tick();
    check("orphan_outstanding", 32'(outstanding), 32'd0);
    check("orphan_pending", pending, 32'h0);
    ll_rd = 0; #1;
    check("ll_rd0_we", 32'(rf_write_en), 32'd0);
    check("ll_rd0_ready", 32'(ll_ready), 32'd1);
    ll_valid = 0; wb_en = 0; #1;
    check("idle_rd", 32'(rf_rd), 32'd0);
    check("idle_data", rf_write_data, 32'h0);

    // Issue to x0 counts but marks nothing
    iss_valid = 1; iss_rd = 0; tick();
    iss_valid = 0;
    check("x0_outstanding", 32'(outstanding), 32'd1);
    check("x0_pending", pending, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
